// File: rtl/account_session_if.sv
// Card-session bus between the card reader/keypad front end and account_session_ctrl.
// The front end drives the master side; the controller uses the slave side.
interface account_session_if #(
  parameter int CARD_WIDTH     = 6,
  parameter int PASSWORD_WIDTH = 16,
  parameter int BALANCE_WIDTH  = 20,
  parameter int TRY_W          = 2
);
  logic [CARD_WIDTH-1:0]     card_number;
  logic                      card_in;
  logic                      card_out;
  logic                      psw_valid;
  logic [PASSWORD_WIDTH-1:0] password_input;
  logic                      op_done;
  logic [BALANCE_WIDTH-1:0]  updated_balance;
  logic                      unlock_en;
  logic [CARD_WIDTH-1:0]     unlock_card;
  logic [BALANCE_WIDTH-1:0]  balance;
  logic                      authenticated;
  logic                      wrong_psw;
  logic                      card_locked;
  logic                      invalid_card;
  logic [TRY_W-1:0]          tries_left;

  modport master (
    output card_number, card_in, card_out, psw_valid, password_input,
           op_done, updated_balance, unlock_en, unlock_card,
    input  balance, authenticated, wrong_psw, card_locked, invalid_card, tries_left
  );

  modport slave (
    input  card_number, card_in, card_out, psw_valid, password_input,
           op_done, updated_balance, unlock_en, unlock_card,
    output balance, authenticated, wrong_psw, card_locked, invalid_card, tries_left
  );
endinterface

// File: rtl/account_session_ctrl.sv
// Per-user password/balance store running one card session at a time, with
// bounded password attempts, permanent lockout and balance write-back.
module account_session_ctrl #(
  parameter int    CARD_WIDTH     = 6,
  parameter int    PASSWORD_WIDTH = 16,
  parameter int    BALANCE_WIDTH  = 20,
  parameter int    USERS_NUM      = 10,
  parameter int    MAX_TRIES      = 3,
  parameter string PSW_FILE       = "password_memory.txt",
  parameter string BAL_FILE       = "balance_memory.txt",
  parameter int    TRY_W          = $clog2(MAX_TRIES + 1),
  // Reset contents of the password and balance memories
  parameter logic [PASSWORD_WIDTH-1:0] PSW_INIT [USERS_NUM] = '{default: '0},
  parameter logic [BALANCE_WIDTH-1:0]  BAL_INIT [USERS_NUM] = '{default: '0}
) (
  input logic         clk,
  input logic         rst,
  account_session_if.slave bus
);
  localparam int IDX_W = (USERS_NUM > 1) ? $clog2(USERS_NUM) : 1;
  localparam logic [CARD_WIDTH-1:0] USERS_LIM = CARD_WIDTH'(USERS_NUM);

  typedef enum logic [1:0] {IDLE, WAIT_PSW, AUTH, LOCKED} state_t;

  state_t                    state, state_n;
  logic [IDX_W-1:0]          idx, idx_n;
  logic [TRY_W-1:0]          tries, tries_n;
  logic [BALANCE_WIDTH-1:0]  bal_q, bal_n;
  logic                      wrong_q, wrong_n;
  logic                      inv_q, inv_n;
  logic                      lock_set, bal_we, unlock_hit;
  logic [USERS_NUM-1:0]      lock_flag;
  logic [PASSWORD_WIDTH-1:0] password_mem [USERS_NUM];
  logic [BALANCE_WIDTH-1:0]  balance_mem  [USERS_NUM];

  always_ff @(posedge clk)
    if (!rst) password_mem <= PSW_INIT;

  // Reset has priority, so an op_done in a reset cycle is dropped
  always_ff @(posedge clk)
    if (!rst) balance_mem <= BAL_INIT;
    else if (bal_we) balance_mem[idx] <= bus.updated_balance;

  assign unlock_hit = bus.unlock_en && (bus.unlock_card < USERS_LIM);

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    tries_n  = tries;
    bal_n    = bal_q;
    wrong_n  = 1'b0;
    inv_n    = 1'b0;
    lock_set = 1'b0;
    bal_we   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.card_in) begin
          if (bus.card_number >= USERS_LIM) begin
            inv_n = 1'b1;
          end else if (lock_flag[bus.card_number[IDX_W-1:0]]) begin
            state_n = LOCKED;
          end else begin
            idx_n   = bus.card_number[IDX_W-1:0];
            tries_n = TRY_W'(MAX_TRIES);
            state_n = WAIT_PSW;
          end
        end
      end
      WAIT_PSW: begin
        if (bus.card_out) begin
          state_n = IDLE;
          bal_n   = '0;
          tries_n = '0;
        end else if (bus.psw_valid) begin
          if (bus.password_input == password_mem[idx]) begin
            state_n = AUTH;
            bal_n   = balance_mem[idx];
          end else begin
            wrong_n = 1'b1;
            tries_n = tries - TRY_W'(1);
            if (tries == TRY_W'(1)) begin
              lock_set = 1'b1;
              state_n  = LOCKED;
            end
          end
        end
      end
      AUTH: begin
        if (bus.op_done) begin
          bal_we = 1'b1;
          bal_n  = bus.updated_balance;
        end
        if (bus.card_out) begin
          state_n = IDLE;
          bal_n   = '0;
          tries_n = '0;
        end
      end
      LOCKED: begin
        if (bus.card_out) begin
          state_n = IDLE;
          bal_n   = '0;
          tries_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      tries     <= '0;
      bal_q     <= '0;
      wrong_q   <= 1'b0;
      inv_q     <= 1'b0;
      lock_flag <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      tries   <= tries_n;
      bal_q   <= bal_n;
      wrong_q <= wrong_n;
      inv_q   <= inv_n;
      if (lock_set)   lock_flag[idx] <= 1'b1;
      if (unlock_hit) lock_flag[bus.unlock_card[IDX_W-1:0]] <= 1'b0;
    end
  end

  assign bus.balance       = bal_q;
  assign bus.authenticated = (state == AUTH);
  assign bus.card_locked   = (state == LOCKED);
  assign bus.wrong_psw     = wrong_q;
  assign bus.invalid_card  = inv_q;
  assign bus.tries_left    = tries;
endmodule

// File: tb/tb_account_session_ctrl.sv
// Scoreboard bench for account_session_ctrl: the driver queues the expected
// registered outputs after each edge, a monitor pops and compares them.
module tb_account_session_ctrl;
  localparam int CW = 6, PW = 16, BW = 20, UN = 10, MT = 3;
  localparam int TW = $clog2(MT + 1);
  localparam logic [PW-1:0] PSW_TAB [UN] =
    '{16'h0, 16'h0, 16'h0, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  localparam logic [BW-1:0] BAL_TAB [UN] =
    '{20'd0, 20'd0, 20'd0, 20'd500, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0};

  typedef struct {
    string          name;
    logic           auth, locked, wrong, inv;
    logic [TW-1:0]  tries;
    logic [BW-1:0]  bal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic done = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  account_session_if #(.CARD_WIDTH(CW), .PASSWORD_WIDTH(PW), .BALANCE_WIDTH(BW), .TRY_W(TW)) bus();

  account_session_ctrl #(
    .CARD_WIDTH(CW), .PASSWORD_WIDTH(PW), .BALANCE_WIDTH(BW), .USERS_NUM(UN),
    .MAX_TRIES(MT), .PSW_FILE(""), .BAL_FILE(""), .TRY_W(TW),
    .PSW_INIT(PSW_TAB), .BAL_INIT(BAL_TAB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (bus.authenticated !== e.auth || bus.card_locked !== e.locked ||
          bus.wrong_psw !== e.wrong || bus.invalid_card !== e.inv ||
          bus.tries_left !== e.tries || bus.balance !== e.bal) begin
        n_bad++;
        $display("FAIL %s: got auth=%0b lock=%0b wrong=%0b inv=%0b tries=%0d bal=%0d, want auth=%0b lock=%0b wrong=%0b inv=%0b tries=%0d bal=%0d",
                 e.name, bus.authenticated, bus.card_locked, bus.wrong_psw, bus.invalid_card,
                 bus.tries_left, bus.balance, e.auth, e.locked, e.wrong, e.inv, e.tries, e.bal);
      end
    end else if (done) begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
    $fatal(1, "watchdog");
  end

  task automatic step(input string nm, input logic a, input logic l, input logic w,
                      input logic i, input int t, input int b);
    exp_t e;
    e.name = nm; e.auth = a; e.locked = l; e.wrong = w; e.inv = i;
    e.tries = TW'(t); e.bal = BW'(b);
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    bus.card_in = 1'b0; bus.card_out = 1'b0; bus.psw_valid = 1'b0;
    bus.op_done = 1'b0; bus.unlock_en = 1'b0;
  endtask

  task automatic card(input int c);
    bus.card_in = 1'b1; bus.card_number = CW'(c);
  endtask

  task automatic psw(input logic [PW-1:0] p);
    bus.psw_valid = 1'b1; bus.password_input = p;
  endtask

  initial begin
    bus.card_number = '0; bus.card_in = 1'b0; bus.card_out = 1'b0;
    bus.psw_valid = 1'b0; bus.password_input = '0; bus.op_done = 1'b0;
    bus.updated_balance = '0; bus.unlock_en = 1'b0; bus.unlock_card = '0;

    rst = 1'b0;
    step("reset_a", 0, 0, 0, 0, 0, 0);
    step("reset_b", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    card(3);                 step("c3_in", 0, 0, 0, 0, 3, 0);
    psw(16'h1234);           step("c3_login", 1, 0, 0, 0, 3, 500);
    n_cmp++;
    if (bus.balance !== BW'(500)) begin
      n_bad++;
      $display("FAIL direct_login_balance: got %0d, want 500", bus.balance);
    end
    card(5);                 step("card_in_in_auth", 1, 0, 0, 0, 3, 500);
    bus.op_done = 1'b1; bus.updated_balance = 20'd300;
                             step("op_done_300", 1, 0, 0, 0, 3, 300);
    bus.card_out = 1'b1;     step("card_out", 0, 0, 0, 0, 0, 0);
                             step("idle_quiet", 0, 0, 0, 0, 0, 0);
    card(3);                 step("c3_reinsert", 0, 0, 0, 0, 3, 0);
    psw(16'h1234);           step("c3_bal_300", 1, 0, 0, 0, 3, 300);
    bus.card_out = 1'b1;     step("out2", 0, 0, 0, 0, 0, 0);

    card(3);                 step("c3_in_prio", 0, 0, 0, 0, 3, 0);
    psw(16'h1111); bus.card_out = 1'b1;
                             step("out_over_psw", 0, 0, 0, 0, 0, 0);

    card(3);                 step("c3_in_lock", 0, 0, 0, 0, 3, 0);
    psw(16'h1111);           step("wrong1", 0, 0, 1, 0, 2, 0);
    psw(16'h2222);           step("wrong2", 0, 0, 1, 0, 1, 0);
    psw(16'h3333);           step("wrong3_lock", 0, 1, 1, 0, 0, 0);
    n_cmp++;
    if (bus.card_locked !== 1'b1) begin
      n_bad++;
      $display("FAIL direct_lockout: got card_locked=%0b, want 1", bus.card_locked);
    end
    psw(16'h1234);           step("locked_ignores_psw", 0, 1, 0, 0, 0, 0);
    bus.card_out = 1'b1;     step("out_locked", 0, 0, 0, 0, 0, 0);
    card(3);                 step("c3_relocked", 0, 1, 0, 0, 0, 0);
    bus.card_out = 1'b1;     step("out3", 0, 0, 0, 0, 0, 0);

    card(12);                step("invalid_pulse", 0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (bus.invalid_card !== 1'b1) begin
      n_bad++;
      $display("FAIL direct_invalid: got invalid_card=%0b, want 1", bus.invalid_card);
    end
                             step("invalid_cleared", 0, 0, 0, 0, 0, 0);
    bus.unlock_en = 1'b1; bus.unlock_card = CW'(13);
                             step("unlock_oor", 0, 0, 0, 0, 0, 0);
    card(3);                 step("c3_still_locked", 0, 1, 0, 0, 0, 0);
    bus.card_out = 1'b1;     step("out4", 0, 0, 0, 0, 0, 0);
    bus.unlock_en = 1'b1; bus.unlock_card = CW'(3);
                             step("unlock_c3", 0, 0, 0, 0, 0, 0);
    card(3);                 step("c3_unlocked", 0, 0, 0, 0, 3, 0);
    psw(16'h1234);           step("c3_login_after_unlock", 1, 0, 0, 0, 3, 300);

    bus.op_done = 1'b1; bus.updated_balance = 20'd100; bus.card_out = 1'b1;
                             step("op_and_out", 0, 0, 0, 0, 0, 0);
    card(3);                 step("c3_in_100", 0, 0, 0, 0, 3, 0);
    psw(16'h1234);           step("c3_bal_100", 1, 0, 0, 0, 3, 100);
    bus.card_out = 1'b1;     step("out5", 0, 0, 0, 0, 0, 0);

    card(5);                 step("c5_in", 0, 0, 0, 0, 3, 0);
    psw(16'h0001);           step("c5_wrong1", 0, 0, 1, 0, 2, 0);
    psw(16'h0001);           step("c5_wrong2", 0, 0, 1, 0, 1, 0);
    psw(16'h0001);           step("c5_wrong3", 0, 1, 1, 0, 0, 0);
    bus.card_out = 1'b1;     step("out6", 0, 0, 0, 0, 0, 0);
    card(3);                 step("c3_wait", 0, 0, 0, 0, 3, 0);
    rst = 1'b0;              step("reset_mid_session", 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    card(5);                 step("c5_after_reset", 0, 0, 0, 0, 3, 0);
    psw(16'h0000);           step("c5_login", 1, 0, 0, 0, 3, 0);
    bus.card_out = 1'b1;     step("out7", 0, 0, 0, 0, 0, 0);
    card(3);                 step("c3_after_reset", 0, 0, 0, 0, 3, 0);
    psw(16'h1234);           step("c3_bal_reloaded", 1, 0, 0, 0, 3, 500);
    n_cmp++;
    if (bus.authenticated !== 1'b1 || bus.balance !== BW'(500)) begin
      n_bad++;
      $display("FAIL direct_reload: got auth=%0b bal=%0d, want auth=1 bal=500",
               bus.authenticated, bus.balance);
    end

    done = 1'b1;
  end
endmodule
